// File: rtl/sa_matmul_if.sv
// sa_matmul_if: weight load, activation stream, result stream and job control for sa_matmul
// slave  (array side): takes weights, activation rows and start; gives in_ready, busy, done, results, row_count
// master (host side):  the mirror image
interface sa_matmul_if #(parameter int N = 3, parameter int DW = 8, parameter int DEPTH = 16);
  localparam int AW = 2*DW + $clog2(N);
  localparam int WA = $clog2(N*N);
  localparam int CW = $clog2(DEPTH) + 1;
  logic w_we;
  logic [WA-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic in_valid;
  logic in_ready;
  logic [N*DW-1:0] in_data;
  logic start;
  logic busy;
  logic done;
  logic out_valid;
  logic out_ready;
  logic [N*AW-1:0] out_data;
  logic [CW-1:0] row_count;
  modport slave (
    input w_we, w_addr, w_data, in_valid, in_data, start, out_ready,
    output in_ready, busy, done, out_valid, out_data, row_count
  );
  modport master (
    output w_we, w_addr, w_data, in_valid, in_data, start, out_ready,
    input in_ready, busy, done, out_valid, out_data, row_count
  );
endinterface

// File: rtl/sa_matmul.sv
// sa_matmul: weight-stationary N x N systolic matrix multiplier with row buffer and result handshake
// clk, rst : clock and synchronous active-high reset
// io       : sa_matmul_if.slave (weight writes, activation rows in, result rows out, start/busy/done, row_count)
module sa_matmul #(
  parameter int N = 3,
  parameter int DW = 8,
  parameter int DEPTH = 16,
  parameter int SIGNED = 0
) (
  input logic clk,
  input logic rst,
  sa_matmul_if.slave io
);
  localparam int AW = 2*DW + $clog2(N);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AD = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [DW-1:0] w [N*N];
  logic [N*DW-1:0] rows [DEPTH];
  logic [CW-1:0] row_count, rd_ptr, out_cnt;
  logic [DW-1:0] sk [N][N-1];
  logic [DW-1:0] a_r [N][N-1];
  logic [DW-1:0] a_in [N][N];
  logic [AW-1:0] p_r [N][N];
  logic [AW-1:0] p_in [N][N];
  logic [AW-1:0] prod [N][N];
  logic [AW-1:0] ds [N][N-1];
  logic [2*N-2:0] vp;
  logic [N*DW-1:0] feed;
  logic [N*AW-1:0] out_data;
  logic feed_vld, acc, adv, hs, last_hs, done_q, done_n, in_ready;
  function automatic logic [AW-1:0] ext(input logic [DW-1:0] x);
    return SIGNED != 0 ? {{(AW-DW){x[DW-1]}}, x} : {{(AW-DW){1'b0}}, x};
  endfunction
  assign in_ready = state == IDLE && row_count != CW'(DEPTH);
  assign io.in_ready = in_ready;
  assign io.busy = state != IDLE;
  assign io.done = done_q;
  assign io.row_count = row_count;
  assign io.out_valid = vp[2*N-2];
  assign io.out_data = out_data;
  // a stalled result freezes every stage so out_data cannot change under the consumer
  always_comb begin
    acc = io.in_valid && in_ready;
    adv = !(io.out_valid && !io.out_ready);
    hs = io.out_valid && io.out_ready;
    last_hs = hs && out_cnt == row_count - 1'b1;
    feed_vld = state == RUN;
    feed = feed_vld ? rows[rd_ptr[AD-1:0]] : '0;
    state_n = state;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = io.start && (row_count != '0 || acc) ? RUN : IDLE;
        done_n = io.start && row_count == '0 && !acc;
      end
      RUN: state_n = adv && rd_ptr == row_count - 1'b1 ? DRAIN : RUN;
      DRAIN: begin
        state_n = last_hs ? IDLE : DRAIN;
        done_n = last_hs;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done_q <= 1'b0;
      row_count <= '0;
      rd_ptr <= '0;
      out_cnt <= '0;
      for (int k = 0; k < N*N; k++) w[k] <= '0;
    end else begin
      state <= state_n;
      done_q <= done_n;
      if (state == IDLE && io.w_we && int'(io.w_addr) < N*N) w[io.w_addr] <= io.w_data;
      if (state != IDLE && state_n == IDLE) begin
        row_count <= '0;
        rd_ptr <= '0;
        out_cnt <= '0;
      end else begin
        if (acc) row_count <= row_count + 1'b1;
        if (feed_vld && adv) rd_ptr <= rd_ptr + 1'b1;
        if (hs) out_cnt <= out_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) if (!rst && acc) rows[row_count[AD-1:0]] <= io.in_data;
  // activations move right along lane i, partial sums move down column j
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0 && i == 0) begin : g_a0
        assign a_in[i][j] = feed[DW-1:0];
      end else if (j == 0) begin : g_as
        assign a_in[i][j] = sk[i][i-1];
      end else begin : g_ap
        assign a_in[i][j] = a_r[i][j-1];
      end
      if (i == 0) begin : g_p0
        assign p_in[i][j] = '0;
      end else begin : g_pp
        assign p_in[i][j] = p_r[i-1][j];
      end
      assign prod[i][j] = ext(a_in[i][j]) * ext(w[i*N+j]);
    end
  end
  // column j leaves the grid N-1-j cycles before the last column; delay it to line the row up
  for (genvar j = 0; j < N; j++) begin : g_out
    if (j == N-1) begin : g_last
      assign out_data[j*AW +: AW] = p_r[N-1][j];
    end else begin : g_dly
      assign out_data[j*AW +: AW] = ds[j][N-2-j];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vp <= '0;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N-1; k++) begin
          sk[i][k] <= '0;
          a_r[i][k] <= '0;
          ds[i][k] <= '0;
        end
        for (int j = 0; j < N; j++) p_r[i][j] <= '0;
      end
    end else if (adv) begin
      vp <= {vp[2*N-3:0], feed_vld};
      for (int i = 0; i < N; i++) begin
        sk[i][0] <= feed[i*DW +: DW];
        ds[i][0] <= p_r[N-1][i];
        for (int k = 1; k < N-1; k++) begin
          sk[i][k] <= sk[i][k-1];
          ds[i][k] <= ds[i][k-1];
        end
        for (int k = 0; k < N-1; k++) a_r[i][k] <= a_in[i][k];
        for (int j = 0; j < N; j++) p_r[i][j] <= p_in[i][j] + prod[i][j];
      end
    end
  end
endmodule

// File: tb/tb_sa_matmul.sv
// tb_sa_matmul: scoreboard bench driving an unsigned and a signed sa_matmul with identical stimulus
module tb_sa_matmul;
  localparam int N = 3, DW = 8, DEPTH = 16, AW = 18;
  logic clk = 0, rst = 1;
  logic w_we = 0, in_valid = 0, start = 0, out_ready = 1;
  logic [3:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic [N*DW-1:0] in_data = '0;
  int n_chk = 0, n_err = 0, cyc = 0, first_v = -1, start_cyc = 0, done_at = 0, last_hs = 0, done_cnt = 0;
  logic [DW-1:0] wm [N*N];
  logic [N*DW-1:0] rows_q [$];
  logic [N*AW-1:0] exp_u [$];
  logic [N*AW-1:0] exp_s [$];
  sa_matmul_if #(.N(N), .DW(DW), .DEPTH(DEPTH)) bu ();
  sa_matmul_if #(.N(N), .DW(DW), .DEPTH(DEPTH)) bs ();
  assign bu.w_we = w_we;
  assign bu.w_addr = w_addr;
  assign bu.w_data = w_data;
  assign bu.in_valid = in_valid;
  assign bu.in_data = in_data;
  assign bu.start = start;
  assign bu.out_ready = out_ready;
  assign bs.w_we = w_we;
  assign bs.w_addr = w_addr;
  assign bs.w_data = w_data;
  assign bs.in_valid = in_valid;
  assign bs.in_data = in_data;
  assign bs.start = start;
  assign bs.out_ready = out_ready;
  sa_matmul #(.N(N), .DW(DW), .DEPTH(DEPTH), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .io(bu));
  sa_matmul #(.N(N), .DW(DW), .DEPTH(DEPTH), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .io(bs));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*AW-1:0] mm(input logic [N*DW-1:0] r, input bit sgn);
    logic [N*AW-1:0] o;
    o = '0;
    for (int j = 0; j < N; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < N; i++) begin
        logic [DW-1:0] a, b;
        int pa, pb;
        a = r[i*DW +: DW];
        b = wm[i*N+j];
        pa = sgn ? int'($signed(a)) : int'(a);
        pb = sgn ? int'($signed(b)) : int'(b);
        s += pa * pb;
      end
      o[j*AW +: AW] = s[AW-1:0];
    end
    return o;
  endfunction
  function automatic logic [N*DW-1:0] row3(input int a, input int b, input int c);
    return {c[7:0], b[7:0], a[7:0]};
  endfunction
  always @(negedge clk) if (!rst) begin
    if (bu.done) done_cnt++;
    if (bu.out_valid) begin
      if (first_v < 0) first_v = cyc;
      if (exp_u.size() == 0) check("spurious_u", bu.out_valid, 1'b0);
      else if (bu.out_ready) begin
        check("row_u", bu.out_data, exp_u.pop_front());
        last_hs = cyc;
      end else check("stall_u", bu.out_data, exp_u[0]);
    end
  end
  always @(negedge clk) if (!rst && bs.out_valid) begin
    if (exp_s.size() == 0) check("spurious_s", bs.out_valid, 1'b0);
    else if (bs.out_ready) check("row_s", bs.out_data, exp_s.pop_front());
    else check("stall_s", bs.out_data, exp_s[0]);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put_w(input int a, input int v);
    w_we = 1;
    w_addr = a[3:0];
    w_data = v[7:0];
    tick();
    w_we = 0;
    wm[a] = v[7:0];
  endtask
  task automatic push(input logic [N*DW-1:0] r);
    in_valid = 1;
    in_data = r;
    if (bu.in_ready) rows_q.push_back(r);
    tick();
    in_valid = 0;
  endtask
  task automatic start_job(input bit wr, input logic [N*DW-1:0] r);
    start = 1;
    if (wr) begin
      in_valid = 1;
      in_data = r;
      if (bu.in_ready) rows_q.push_back(r);
    end
    foreach (rows_q[k]) begin
      exp_u.push_back(mm(rows_q[k], 0));
      exp_s.push_back(mm(rows_q[k], 1));
    end
    rows_q.delete();
    start_cyc = cyc;
    first_v = -1;
    tick();
    start = 0;
    in_valid = 0;
  endtask
  task automatic wait_done(input int lim, input bit tog);
    int k;
    k = 0;
    while (bu.done !== 1'b1 && k < lim) begin
      if (tog) out_ready = ~out_ready;
      tick();
      k++;
    end
    check("done_seen", bu.done, 1'b1);
    check("done_s", bs.done, 1'b1);
    done_at = cyc;
    out_ready = 1;
    check("drain_u", exp_u.size(), 0);
    check("drain_s", exp_s.size(), 0);
    check("busy_end", bu.busy, 1'b0);
    check("cnt_end", bu.row_count, 0);
  endtask
  task automatic job(input int lim);
    start_job(0, '0);
    wait_done(lim, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int dc;
    for (int k = 0; k < N*N; k++) wm[k] = '0;
    in_valid = 1;
    start = 1;
    w_we = 1;
    w_data = 8'h55;
    in_data = row3(9, 9, 9);
    tick();
    tick();
    rst = 0;
    in_valid = 0;
    start = 0;
    w_we = 0;
    w_data = 0;
    check("rst_busy", bu.busy, 1'b0);
    check("rst_done", bu.done, 1'b0);
    check("rst_ov", bu.out_valid, 1'b0);
    check("rst_od", bu.out_data, 0);
    check("rst_rdy", bu.in_ready, 1'b1);
    check("rst_cnt", bu.row_count, 0);
    for (int a = 0; a < N*N; a++) put_w(a, (a / N == a % N) ? 1 : 0);
    push(row3(1, 2, 3));
    push(row3(4, 5, 6));
    check("cnt2", bu.row_count, 2);
    job(40);
    check("lat_first", first_v - start_cyc, 6);
    check("lat_done", done_at - start_cyc, 8);
    tick();
    check("done_pulse", bu.done, 1'b0);
    for (int a = 0; a < N*N; a++) put_w(a, 255);
    push(row3(255, 255, 255));
    job(40);
    for (int a = 0; a < N*N; a++) put_w(a, 128);
    push(row3(128, 128, 128));
    job(40);
    for (int a = 0; a < N*N; a++) put_w(a, 1);
    push(row3(127, 128, 0));
    job(40);
    for (int a = 0; a < N*N; a++) put_w(a, $urandom_range(0, 255));
    for (int k = 0; k < 3; k++) push(row3($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)));
    start_job(1, row3($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)));
    check("busy_run", bu.busy, 1'b1);
    w_we = 1;
    w_addr = 0;
    w_data = ~wm[0];
    tick();
    w_we = 0;
    wait_done(100, 1);
    check("done_after_hs", done_at - last_hs, 1);
    push(row3($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)));
    job(40);
    in_valid = 1;
    for (int k = 0; k < 17; k++) begin
      in_data = row3($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      if (bu.in_ready) rows_q.push_back(in_data);
      tick();
    end
    in_valid = 0;
    check("full_cnt", bu.row_count, 16);
    check("full_rdy", bu.in_ready, 1'b0);
    job(100);
    start = 1;
    tick();
    start = 0;
    check("empty_done", bu.done, 1'b1);
    check("empty_busy", bu.busy, 1'b0);
    check("empty_ov", bu.out_valid, 1'b0);
    tick();
    check("empty_done2", bu.done, 1'b0);
    for (int k = 0; k < 5; k++) push(row3($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)));
    start_job(0, '0);
    tick();
    tick();
    rst = 1;
    tick();
    check("abort_busy", bu.busy, 1'b0);
    check("abort_ov", bu.out_valid, 1'b0);
    rst = 0;
    exp_u.delete();
    exp_s.delete();
    for (int k = 0; k < N*N; k++) wm[k] = '0;
    dc = done_cnt;
    repeat (20) tick();
    check("abort_nodone", done_cnt, dc);
    check("abort_cnt", bu.row_count, 0);
    for (int a = 0; a < N*N; a++) put_w(a, $urandom_range(0, 255));
    push(row3($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)));
    push(row3($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)));
    job(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sa_matmul.md
SA_MATMUL -- requirements
Module: sa_matmul

Interface
REQ-001 SHALL have parameter N, default 3: systolic array dimension (N x N weight-stationary MAC grid); legal 2..8.
REQ-002 SHALL have parameter DW, default 8: operand width (activations, weights).
REQ-003 SHALL have parameter DEPTH, default 16: maximum activation rows per job (power of 2).
REQ-004 SHALL have parameter SIGNED, default 0: 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL derive AW = 2*DW + clog2(N): accumulator/result width per column.
REQ-006 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port w_we  input  1  weight write strobe.
REQ-009 SHALL have port w_addr  input  clog2(N*N)  weight index, row-major (i*N+j = input lane i, output column j).
REQ-010 SHALL have port w_data  input  DW  weight value.
REQ-011 SHALL have port in_valid  input  1  activation row valid.
REQ-012 SHALL have port in_ready  output  1  activation row accepted when high with in_valid.
REQ-013 SHALL have port in_data  input  N*DW  activation row; lane i at bits [i*DW +: DW].
REQ-014 SHALL have port start  input  1  single-cycle job launch pulse.
REQ-015 SHALL have port busy  output  1  high from accepted start until done pulse.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last result row is accepted.
REQ-017 SHALL have port out_valid  output  1  result row valid.
REQ-018 SHALL have port out_ready  input  1  result row consumer ready.
REQ-019 SHALL have port out_data  output  N*AW  result row; column j at bits [j*AW +: AW].
REQ-020 SHALL have port row_count  output  clog2(DEPTH)+1  activation rows currently buffered.

Function
REQ-021 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; IDLE on reset.
REQ-022 IDLE: in_ready = (row_count < DEPTH); each in_valid&&in_ready handshake stores in_data at buffer slot row_count, row_count += 1.
REQ-023 Writes to a full buffer SHALL NOT occur: in_ready low at row_count == DEPTH; in_valid then ignored, no wrap-around.
REQ-024 w_we in IDLE SHALL update weight[w_addr] next cycle; w_we while busy SHALL be ignored; w_addr >= N*N ignored.
REQ-025 start in IDLE with row_count > 0 SHALL enter RUN next cycle, busy = 1; start while busy ignored.
REQ-026 start in IDLE with row_count == 0 SHALL produce done pulse next cycle, busy stays 0, no out_valid.
REQ-027 start and in_valid same IDLE cycle: row accepted first and included in the job.
REQ-028 RUN: buffered rows fed in order row 0 first, lane i delayed i cycles (input skew); result columns de-skewed so out_data presents one complete row.
REQ-029 Result row m, column j SHALL equal sum over i of A[m][i]*W[i][j], full AW precision, no overflow/truncation; SIGNED selects sign extension.
REQ-030 With out_ready held high, first out_valid SHALL assert exactly 2*N cycles after start cycle; subsequent rows one per cycle.
REQ-031 out_valid && !out_ready SHALL freeze the entire pipeline (feed, MACs, skew registers); out_data and out_valid held stable until handshake.
REQ-032 Enter DRAIN after last row fed; leave DRAIN when last row handshakes; done = 1 that cycle+1, busy = 0, row_count = 0, return IDLE.
REQ-033 Weights SHALL persist across jobs until rewritten or reset.
REQ-034 out_valid SHALL never assert in IDLE.

Reset
REQ-035 rst SHALL force next cycle: state IDLE, busy 0, done 0, out_valid 0, out_data 0, in_ready 1, row_count 0, all weights 0, pipeline registers cleared.
REQ-036 rst mid-job SHALL abort: no further out_valid, no done pulse; buffered rows discarded.
REQ-037 rst SHALL take priority over start, w_we, in_valid in the same cycle.

Verification
REQ-038 N=3, identity weights, rows [1,2,3],[4,5,6], start, out_ready=1 -> out_valid at start+6 and +7, out_data [1,2,3] then [4,5,6], done at +8.
REQ-039 SIGNED=0, DW=8, all weights 255, one row [255,255,255] -> every column 195075, no truncation in AW=18.
REQ-040 SIGNED=1, all weights -128, row [-128,-128,-128] -> each column 49152; row [127,-128,0] with weights 1 -> -1.
REQ-041 Backpressure: 4 rows, out_ready toggled 0/1 each cycle -> 4 correct rows in order, data stable while stalled, done after 4th handshake.
REQ-042 Push 17 rows with in_valid held -> in_ready low after 16, row_count = 16, 17th not stored; start with empty buffer -> done next cycle, no out_valid.
REQ-043 rst asserted 3 cycles into a 5-row job -> busy 0, out_valid 0 following cycle, no done, next job from fresh rows correct.
